// File: rtl/clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with boundary-aligned
// retuning, per-channel phase offset and a settle-based lock indication.
module clk_en_gen #(
  parameter  int CHANNELS    = 3,
  parameter  int ACC_W       = 32,
  parameter  int LOCK_CYCLES = 256,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] pend,
  output logic                locked
);

  localparam int             CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [ACC_W-1:0]    acc_q     [CHANNELS];
  logic [ACC_W-1:0]    acc_d     [CHANNELS];
  logic [ACC_W-1:0]    inc_q     [CHANNELS];
  logic [ACC_W-1:0]    inc_d     [CHANNELS];
  logic [ACC_W-1:0]    phase_q   [CHANNELS];
  logic [ACC_W-1:0]    phase_d   [CHANNELS];
  logic [ACC_W-1:0]    p_inc_q   [CHANNELS];
  logic [ACC_W-1:0]    p_inc_d   [CHANNELS];
  logic [ACC_W-1:0]    p_phase_q [CHANNELS];
  logic [ACC_W-1:0]    p_phase_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                locked_q;

  logic             wr, run, start, carry, apply, any_clr;
  logic [ACC_W:0]   sum;

  always_comb begin
    wr      = 1'b0;
    run     = 1'b0;
    start   = 1'b0;
    carry   = 1'b0;
    apply   = 1'b0;
    sum     = '0;
    any_clr = 1'b0;
    ce_d    = '0;
    pend_d  = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      wr    = cfg_we && (cfg_ch == CH_W'(i));
      run   = enable[i] && en_q[i];
      start = enable[i] && !en_q[i];
      sum   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      carry = run && sum[ACC_W];
      // A held write lands on a period boundary, or at once when the channel cannot pulse.
      apply = pend_q[i] && (carry || !enable[i] || (inc_q[i] == '0));

      acc_d[i] = acc_q[i];
      if (run) begin
        acc_d[i] = sum[ACC_W-1:0];
      end else if (start) begin
        acc_d[i] = phase_q[i];
      end
      ce_d[i] = carry;

      inc_d[i]     = apply ? p_inc_q[i]   : inc_q[i];
      phase_d[i]   = apply ? p_phase_q[i] : phase_q[i];
      p_inc_d[i]   = wr    ? cfg_inc      : p_inc_q[i];
      p_phase_d[i] = wr    ? cfg_phase    : p_phase_q[i];
      pend_d[i]    = wr || (pend_q[i] && !apply);

      if (apply || start) begin
        any_clr = 1'b1;
      end
    end

    if (any_clr) begin
      cnt_d = '0;
    end else if (cnt_q == LOCK_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]     <= '0;
        inc_q[i]     <= '0;
        phase_q[i]   <= '0;
        p_inc_q[i]   <= '0;
        p_phase_q[i] <= '0;
      end
      pend_q   <= '0;
      en_q     <= '0;
      ce_q     <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]     <= acc_d[i];
        inc_q[i]     <= inc_d[i];
        phase_q[i]   <= phase_d[i];
        p_inc_q[i]   <= p_inc_d[i];
        p_phase_q[i] <= p_phase_d[i];
      end
      pend_q   <= pend_d;
      en_q     <= enable;
      ce_q     <= ce_d;
      cnt_q    <= cnt_d;
      locked_q <= (cnt_d == LOCK_MAX);
    end
  end

  assign ce     = ce_q;
  assign pend   = pend_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen at ACC_W=8, CHANNELS=3, LOCK_CYCLES=16.
module tb_clk_en_gen;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic [7:0] cfg_phase = '0;
  logic [2:0] enable = '0;
  logic [2:0] ce, pend;
  logic       locked;

  int nvec = 0;
  int nerr = 0;
  int npulse;
  bit found;

  clk_en_gen #(.CHANNELS(3), .ACC_W(8), .LOCK_CYCLES(16)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .enable(enable),
    .ce(ce), .pend(pend), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input logic [7:0] inc, input logic [7:0] ph);
    cfg_we    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = inc;
    cfg_phase = ph;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    // Reset with random activity on the inputs
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ce", 32'(ce), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_locked", 32'(locked), 0);
    for (int k = 0; k < 4; k++) begin
      enable    = 3'($urandom);
      cfg_we    = 1'b1;
      cfg_ch    = 2'($urandom);
      cfg_inc   = 8'($urandom);
      cfg_phase = 8'($urandom);
      tick();
    end
    chk("rst_hold_ce", 32'(ce), 0);
    chk("rst_hold_pend", 32'(pend), 0);
    cfg_we = 1'b0;
    enable = 3'b000;
    rst_n  = 1'b1;
    tick();
    enable = 3'b111;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ce != 0) npulse++;
    end
    chk("no_ce_unconfigured", 32'(npulse), 0);
    enable = 3'b000;
    tick();

    // Steady rate on ch0
    wr(0, 8'h40, 8'h00);
    chk("pend_rise", 32'(pend), 32'b001);
    tick();
    chk("pend_stopped_apply", 32'(pend), 0);
    enable = 3'b001;
    tick();
    chk("start_no_ce", 32'(ce), 0);
    npulse = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (ce[0]) npulse++;
      if (k <= 8) chk($sformatf("steady_k%0d", k), 32'(ce), (k % 4 == 0) ? 32'b001 : 32'b000);
    end
    chk("steady_count", 32'(npulse), 64);
    chk("steady_locked", 32'(locked), 1);

    // Retune one cycle after a pulse
    wr(0, 8'h80, 8'h00);
    chk("retune_pend", 32'(pend), 32'b001);
    chk("retune_ce257", 32'(ce), 0);
    tick();
    chk("retune_ce258", 32'(ce), 0);
    tick();
    chk("retune_ce259", 32'(ce), 0);
    chk("retune_pend259", 32'(pend), 32'b001);
    chk("retune_locked259", 32'(locked), 1);
    tick();
    chk("retune_boundary_ce", 32'(ce), 32'b001);
    chk("retune_pend_clear", 32'(pend), 0);
    chk("retune_locked_drop", 32'(locked), 0);
    tick();
    chk("retune_ce261", 32'(ce), 0);
    tick();
    chk("retune_ce262", 32'(ce), 32'b001);
    tick();
    chk("retune_ce263", 32'(ce), 0);
    tick();
    chk("retune_ce264", 32'(ce), 32'b001);

    // Phase offset between ch0 and ch1
    enable = 3'b000;
    tick();
    wr(0, 8'h40, 8'h00);
    wr(1, 8'h40, 8'h80);
    chk("phase_pend", 32'(pend), 32'b010);
    tick();
    chk("phase_pend_clear", 32'(pend), 0);
    enable = 3'b011;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("phase_j%0d", j), 32'(ce),
          (j % 4 == 2) ? 32'b010 : ((j % 4 == 0) ? 32'b001 : 32'b000));
    end

    // Immediate apply on stopped ch2, then lock count
    wr(2, 8'h20, 8'h10);
    chk("ch2_pend", 32'(pend), 32'b100);
    tick();
    chk("ch2_pend_clear", 32'(pend), 0);
    for (int k = 0; k < 15; k++) tick();
    chk("lock_edge15", 32'(locked), 0);
    tick();
    chk("lock_edge16", 32'(locked), 1);

    // Invalid target
    wr(3, 8'hFF, 8'hFF);
    chk("invalid_pend", 32'(pend), 0);
    chk("invalid_locked", 32'(locked), 1);
    tick();
    chk("invalid_pend2", 32'(pend), 0);
    chk("invalid_locked2", 32'(locked), 1);

    // Start clears lock
    enable = 3'b111;
    tick();
    chk("start_locked_drop", 32'(locked), 0);

    // Simultaneous write and carry on ch0
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (ce[0]) found = 1'b1;
    end
    chk("wait_ce0", 32'(found), 1);
    wr(0, 8'h80, 8'h00);
    chk("sim_pend_a", 32'(pend[0]), 1);
    tick();
    tick();
    wr(0, 8'h20, 8'h00);
    chk("sim_carry_ce", 32'(ce[0]), 1);
    chk("sim_new_pending", 32'(pend[0]), 1);
    tick();
    chk("sim_ce_next", 32'(ce[0]), 0);
    chk("sim_pend_next", 32'(pend[0]), 1);
    wr(1, 8'h10, 8'h00);
    chk("sim_old_applied_ce", 32'(ce[0]), 1);
    chk("sim_pend_final", 32'(pend), 32'b010);

    // Asynchronous reset mid-run
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ce", 32'(ce), 0);
    chk("midrst_pend", 32'(pend), 0);
    chk("midrst_locked", 32'(locked), 0);
    tick();
    rst_n = 1'b1;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ce != 0) npulse++;
    end
    chk("post_rst_no_ce", 32'(npulse), 0);
    chk("post_rst_pend", 32'(pend), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
